// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-side blocks: the sequencer FSM state
// encoding and the program-counter step (PC is a word index).
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int unsigned PC_STEP = 1;

endpackage

// File: rtl/cycle_counter.sv
// Modulo-N counter with count enable, synchronous clear and a terminal-count
// flag that is high while the count sits at N-1.
module cycle_counter #(
  parameter int unsigned N  = 30,
  parameter int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_r;

  assign count = count_r;
  assign tc    = (count_r == LAST);

  // Count register: wraps to zero after the terminal count, clear wins over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      if (tc) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the non-pipelined MIPS core: holds each PC for
// CYCLES_PER_INSTR enabled cycles, then advances to PC+1 or a pending redirect
// target, with halt at an instruction boundary.
// Optional feature: define PC_SEQ_RETIRE_CNT_EN to build the retired-instruction counter.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH            = 32,
  parameter int unsigned      CYCLES_PER_INSTR = 30,
  parameter logic [WIDTH-1:0] RESET_PC         = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  output logic [WIDTH-1:0] PC,
  output logic             instr_start,
  output logic             instr_done,
  output logic             halted,
  output logic [31:0]      retired
);

  localparam int unsigned CW = $clog2(CYCLES_PER_INSTR);

  seq_state_t       state_r;
  logic [WIDTH-1:0] pc_r;
  logic             pend_v_r;
  logic [WIDTH-1:0] pend_pc_r;
  logic             halt_r;

  logic [CW-1:0]    cnt_s;
  logic             tc_s;
  logic             run_s;
  logic             boundary_s;
  logic [WIDTH-1:0] next_pc_s;

  assign run_s      = (state_r == RUN);
  assign boundary_s = run_s & enable & tc_s;

  cycle_counter #(
    .N  (CYCLES_PER_INSTR),
    .CW (CW)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (~run_s),
    .en    (run_s & enable),
    .count (cnt_s),
    .tc    (tc_s)
  );

  // Next PC: a redirect in the boundary cycle itself beats an older pending one.
  always_comb begin
    next_pc_s = pc_r + WIDTH'(PC_STEP);
    if (redirect_valid) begin
      next_pc_s = redirect_pc;
    end else if (pend_v_r) begin
      next_pc_s = pend_pc_r;
    end else begin
      next_pc_s = pc_r + WIDTH'(PC_STEP);
    end
  end

  // Sequencer FSM with PC, pending-redirect and sticky-halt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      pend_v_r  <= 1'b0;
      pend_pc_r <= {WIDTH{1'b0}};
      halt_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (boundary_s) begin
            pc_r     <= next_pc_s;
            pend_v_r <= 1'b0;
            halt_r   <= 1'b0;
            if (halt_r || halt_req) begin
              state_r <= HALTED;
            end else begin
              state_r <= RUN;
            end
          end else begin
            if (redirect_valid) begin
              pend_v_r  <= 1'b1;
              pend_pc_r <= redirect_pc;
            end else begin
              pend_v_r  <= pend_v_r;
            end
            if (halt_req) begin
              halt_r <= 1'b1;
            end else begin
              halt_r <= halt_r;
            end
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pulses are decoded from registered state; a frozen (enable low) cycle is never a start or done.
  assign PC          = pc_r;
  assign instr_start = run_s & enable & (cnt_s == {CW{1'b0}});
  assign instr_done  = boundary_s;
  assign halted      = (state_r == HALTED);

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_r;

  // Retired count advances on the edge that closes each instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= 32'd0;
    end else if (boundary_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign retired = retired_r;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (default timing, and a
// 2-cycle hold starting at all-ones) compared every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        rv;
  logic [31:0] rpc;
  logic        hr;

  logic [31:0] o_pc    [2];
  logic        o_start [2];
  logic        o_done  [2];
  logic        o_halt  [2];
  logic [31:0] o_ret   [2];

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.WIDTH(32), .CYCLES_PER_INSTR(30), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .redirect_valid(rv), .redirect_pc(rpc),
    .halt_req(hr), .PC(o_pc[0]), .instr_start(o_start[0]), .instr_done(o_done[0]),
    .halted(o_halt[0]), .retired(o_ret[0]));

  pc_sequencer #(.WIDTH(32), .CYCLES_PER_INSTR(2), .RESET_PC(32'hFFFF_FFFF)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .redirect_valid(rv), .redirect_pc(rpc),
    .halt_req(hr), .PC(o_pc[1]), .instr_start(o_start[1]), .instr_done(o_done[1]),
    .halted(o_halt[1]), .retired(o_ret[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what each instance must be doing in the current cycle.
  bit          m_valid = 1'b0;
  logic [31:0] m_pc   [2];
  int          m_cnt  [2];
  int          m_st   [2];
  bit          m_pv   [2];
  logic [31:0] m_ppc  [2];
  bit          m_halt [2];
  logic [31:0] m_ret  [2];

  function automatic int cpi(input int i);
    return (i == 0) ? 30 : 2;
  endfunction

  function automatic logic [31:0] rstpc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] t=%0t actual=%h required=%h", nm, idx, $time, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    if (reset) begin
      m_valid = 1'b1;
      m_pc[i] = rstpc(i); m_cnt[i] = 0; m_st[i] = S_IDLE;
      m_pv[i] = 1'b0; m_ppc[i] = 32'd0; m_halt[i] = 1'b0; m_ret[i] = 32'd0;
    end else if (m_st[i] == S_IDLE) begin
      if (enable) m_st[i] = S_RUN;
    end else if (m_st[i] == S_RUN) begin
      if (enable && m_cnt[i] == cpi(i) - 1) begin
        m_pc[i]  = rv ? rpc : (m_pv[i] ? m_ppc[i] : m_pc[i] + 32'd1);
        m_cnt[i] = 0;
        m_pv[i]  = 1'b0;
        m_ret[i] = m_ret[i] + 32'd1;
        if (m_halt[i] || hr) m_st[i] = S_HALT;
        m_halt[i] = 1'b0;
      end else begin
        if (rv) begin
          m_pv[i] = 1'b1;
          m_ppc[i] = rpc;
        end
        if (hr) m_halt[i] = 1'b1;
        if (enable) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  // Mid-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        cmp("pc",      i, o_pc[i],           m_pc[i]);
        cmp("start",   i, {31'd0, o_start[i]}, {31'd0, (m_st[i] == S_RUN && m_cnt[i] == 0 && enable)});
        cmp("done",    i, {31'd0, o_done[i]},  {31'd0, (m_st[i] == S_RUN && m_cnt[i] == cpi(i) - 1 && enable)});
        cmp("halted",  i, {31'd0, o_halt[i]},  {31'd0, (m_st[i] == S_HALT)});
`ifdef PC_SEQ_RETIRE_CNT_EN
        cmp("retired", i, o_ret[i], m_ret[i]);
`else
        cmp("retired", i, o_ret[i], 32'd0);
`endif
      end
    end
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then raise enable in IDLE; returns at the start of run cycle 1.
  task automatic start_run();
    reset = 1'b1; enable = 1'b0; rv = 1'b0; hr = 1'b0; rpc = 32'd0;
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rv = 1'b0; hr = 1'b0; rpc = 32'd0;
    tick(); tick();
    cmp("rst_pc0",    0, o_pc[0], 32'h0000_0000);
    cmp("rst_pc1",    1, o_pc[1], 32'hFFFF_FFFF);
    cmp("rst_halted", 0, {31'd0, o_halt[0]}, 32'd0);
    cmp("rst_ret",    0, o_ret[0], 32'd0);
    cmp("rst_start",  0, {31'd0, o_start[0]}, 32'd0);
    cmp("rst_done",   0, {31'd0, o_done[0]}, 32'd0);

    // Plain sequence: PC 0 for cycles 1-30, 1 for 31-60, done at 30 and 60.
    start_run();
    cmp("t1_start1", 0, {31'd0, o_start[0]}, 32'd1);
    for (int c = 1; c <= 60; c++) begin
      cmp("t1_pc",   0, o_pc[0], (c <= 30) ? 32'd0 : 32'd1);
      cmp("t1_done", 0, {31'd0, o_done[0]}, {31'd0, (c == 30 || c == 60)});
      tick();
    end

    // Single redirect mid-instruction.
    start_run();
    for (int c = 1; c <= 61; c++) begin
      rv = (c == 10); rpc = 32'h40;
      if (c == 31) cmp("t2_redir", 0, o_pc[0], 32'h40);
      if (c == 61) cmp("t2_after", 0, o_pc[0], 32'h41);
      tick();
    end

    // Latest redirect wins, including one in the boundary cycle.
    start_run();
    for (int c = 1; c <= 31; c++) begin
      rv  = (c == 5 || c == 20 || c == 30);
      rpc = (c == 5) ? 32'h10 : (c == 20) ? 32'h20 : 32'h30;
      if (c == 31) cmp("t3_latest", 0, o_pc[0], 32'h30);
      tick();
    end

    // Halt at the next boundary; redirects after that are ignored.
    start_run();
    for (int c = 1; c <= 80; c++) begin
      hr = (c == 45); rv = (c == 70); rpc = 32'h99;
      if (c == 60) cmp("t4_pre_pc",  0, o_pc[0], 32'd1);
      if (c == 60) cmp("t4_pre_h",   0, {31'd0, o_halt[0]}, 32'd0);
      if (c == 61) cmp("t4_halt_pc", 0, o_pc[0], 32'd2);
      if (c == 61) cmp("t4_halted",  0, {31'd0, o_halt[0]}, 32'd1);
      if (c == 80) cmp("t4_hold_pc", 0, o_pc[0], 32'd2);
      tick();
    end

    // Wrap from all-ones with a 3-cycle freeze on the 2-cycle instance.
    start_run();
    cmp("t5_pc_c1", 1, o_pc[1], 32'hFFFF_FFFF);
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    cmp("t5_frozen", 1, o_pc[1], 32'hFFFF_FFFF);
    cmp("t5_ret0",   1, o_ret[1], 32'd0);
    enable = 1'b1;
    tick();
    cmp("t5_wrap", 1, o_pc[1], 32'h0000_0000);
`ifdef PC_SEQ_RETIRE_CNT_EN
    cmp("t5_ret", 1, o_ret[1], 32'd1);
`else
    cmp("t5_ret", 1, o_ret[1], 32'd0);
`endif

    // Reset mid-instruction discards a pending redirect.
    start_run();
    for (int c = 1; c <= 14; c++) begin
      rv = (c == 10); rpc = 32'h77;
      tick();
    end
    rv = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; enable = 1'b1;
    cmp("t6_pc",    0, o_pc[0], 32'd0);
    cmp("t6_idle",  0, {31'd0, o_start[0]}, 32'd0);
    tick();
    cmp("t6_start", 0, {31'd0, o_start[0]}, 32'd1);
    for (int c = 1; c <= 31; c++) begin
      if (c == 31) cmp("t6_noredir", 0, o_pc[0], 32'd1);
      tick();
    end

    // Randomized traffic, checked by the per-cycle model compare.
    for (int k = 0; k < 4000; k++) begin
      reset  = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 99) < 85);
      rv     = ($urandom_range(0, 19) == 0);
      rpc    = $urandom();
      hr     = ($urandom_range(0, 249) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
